poly_wavetable_synth: RTL
=========================

Name: poly_wavetable_synth

Overview:
- Polyphonic successor to the single-voice note → phase → sine BRAM → PWM path.
- Runs NUM_VOICES independent phase accumulators, each with a per-voice linear attack/release envelope.
- Reads one shared external wavetable BRAM, time-multiplexed across voices, then mixes all voices into one offset-binary sample per sample tick.
- The output sample feeds the existing pwm block's dc_in.

Parameters:
- NUM_VOICES, 4: voice count; power of two, 2..16.
- SAMPLE_DIV, 2500: clk_in cycles per output sample (40 kHz at 100 MHz); must be ≥ NUM_VOICES+4.
- PHASE_W, 32: phase accumulator width.
- TABLE_AW, 8: wavetable address width (256 entries).
- SAMPLE_W, 8: table data and output sample width, offset binary.
- ENV_W, 8: envelope width; full scale is 2^ENV_W-1.
- ATTACK_STEP, 16: envelope increment per tick while gate is high.
- RELEASE_STEP, 4: envelope decrement per tick while gate is low.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: asynchronous active-high reset.
- voice_gate_in, input, [NUM_VOICES-1:0]: per-voice gate.
- voice_tuning_in, input, [NUM_VOICES-1:0][PHASE_W-1:0]: per-voice phase increment per tick.
- table_addr_out, output, TABLE_AW: wavetable read address, registered.
- table_data_in, input, SAMPLE_W: wavetable data, returned 2 cycles after its address.
- sample_out, output, SAMPLE_W: mixed sample, offset binary.
- sample_valid_out, output, 1: one-cycle pulse when sample_out updates.
- busy_out, output, 1: high while a frame is in flight.

Behaviour:
- Reset (asynchronous, rst_in high):
  - All phases and envelopes = 0; tick counter = 0; FSM = IDLE.
  - table_addr_out = 0; sample_out = 2^(SAMPLE_W-1) (silence); sample_valid_out = 0; busy_out = 0.
  - Reset mid-frame discards the frame; no valid pulse is produced for it.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. The tick is the cycle T in which count == SAMPLE_DIV-1.
- At tick T, updates for every voice v are registered at the end of T:
  - Envelope: gate=1 → env = min(env+ATTACK_STEP, 2^ENV_W-1); gate=0 → env = max(env-RELEASE_STEP, 0).
  - Phase: if gate=0 and env==0 (before the update), phase = 0, so retriggered notes start at phase 0. Otherwise phase += tuning, mod 2^PHASE_W.
- FSM states IDLE → ISSUE → DRAIN → OUTPUT → IDLE.
  - IDLE → ISSUE on tick.
  - ISSUE, cycles T+1..T+N (N = NUM_VOICES): table_addr_out = phase[v][PHASE_W-1 -: TABLE_AW] of the updated phase, v = 0..N-1 in order.
  - DRAIN: 2 cycles.
  - OUTPUT: 1 cycle, then IDLE.
  - busy_out is high from T+1 through T+N+2.
- Datapath, for each data cycle T+3..T+N+2:
  - s = table_data_in XOR MSB (convert to two's complement).
  - p = (s × env[v]) >>> ENV_W, signed, SAMPLE_W bits.
  - acc += p. acc width is SAMPLE_W+log2(N), signed, cleared at T+1.
- Output at cycle T+N+3:
  - mix = acc >>> log2(N).
  - sample_out = mix XOR MSB (back to offset binary); sample_valid_out = 1 for this one cycle.
  - Latency from tick to valid = N+3 cycles; valid period = SAMPLE_DIV.
- Inputs are sampled only at the tick. Gate or tuning changes mid-frame take effect at the next tick.
- A tick can never arrive while busy, given SAMPLE_DIV ≥ N+4. This constraint is checked by an elaboration-time assertion.

Optional Feature:
- Macro: POLY_SYNTH_SOFT_CLIP_EN.
- Defined: mix = acc >>> (log2(N)-1), i.e. 2× gain, saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] before the offset conversion.
- Undefined: plain >>> log2(N) scaling; the output can never clip.

Decomposition:
- Package synth_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, OUTPUT};
  - SAMPLE_W, TABLE_AW and ENV_W defaults;
  - the table read latency constant (2);
  - offset-to-signed and signed-to-offset conversion functions.
- Sub-module voice_envelope: one linear attack/release ramp with tick strobe, gate in and env out, plus an is_silent flag. Instantiated NUM_VOICES times.

Test Plan:
1. Latency/period: defaults, any gates → sample_valid_out pulses exactly 7 cycles after each tick, every 2500 cycles; busy_out is high for 6 cycles.
2. Silence: all gates low → sample_out stays 8'h80 on every valid pulse; table_addr_out stays 0 for all voices.
3. Envelope: voice 0 gate held high, ATTACK_STEP 16 → env = 16, 32, … 240, then saturates at 255 on the 16th tick. After gate drop, env decreases by 4 per tick to 0 and phase returns to 0.
4. Tuning/address: voice 0 tuning 2^24, identity-ramp table (data = addr), gate on → voice-0 addresses increment by 1 per tick and wrap from 255 to 0.
5. Full-scale mix: all 4 voices env 255, table constant 8'hFF.
   - Without the macro: sample_out = 8'hFE (each p=126, acc=504, mix=126).
   - With POLY_SYNTH_SOFT_CLIP_EN: sample_out = 8'hFF (clipped).
6. Reset mid-frame: assert rst_in at T+3 → no valid pulse; sample_out = 8'h80 and busy_out = 0 immediately (asynchronous). The next frame completes normally.

Source files
------------

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared FSM state type, default widths and sample-format helpers for poly_wavetable_synth
package synth_pkg;

    localparam int DEF_SAMPLE_W = 8;
    localparam int DEF_TABLE_AW = 8;
    localparam int DEF_ENV_W    = 8;
    localparam int TABLE_LAT    = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUTPUT
    } synth_state_t;

    // Offset binary and two's complement differ only in the sense of the MSB.
    function automatic logic signed [DEF_SAMPLE_W-1:0] offset_to_signed(
        input logic [DEF_SAMPLE_W-1:0] x
    );
        return {~x[DEF_SAMPLE_W-1], x[DEF_SAMPLE_W-2:0]};
    endfunction

    function automatic logic [DEF_SAMPLE_W-1:0] signed_to_offset(
        input logic signed [DEF_SAMPLE_W-1:0] x
    );
        return {~x[DEF_SAMPLE_W-1], x[DEF_SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/voice_envelope.sv
// rtl/voice_envelope.sv - linear attack/release envelope for one voice, stepping once per sample tick
module voice_envelope #(
    parameter int ENV_W        = 8,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_tick,
    input  logic             i_gate,
    output logic [ENV_W-1:0] o_env,
    output logic             o_is_silent
);

    localparam logic [ENV_W:0]   ENV_MAX_EXT = {1'b0, {ENV_W{1'b1}}};
    localparam logic [ENV_W-1:0] ENV_FULL    = {ENV_W{1'b1}};
    localparam logic [ENV_W:0]   ATK_EXT     = (ENV_W+1)'(ATTACK_STEP);
    localparam logic [ENV_W-1:0] REL_STEP    = ENV_W'(RELEASE_STEP);

    logic [ENV_W-1:0] r_env;
    logic [ENV_W:0]   w_up;
    logic [ENV_W-1:0] w_env_next;

    assign w_up = {1'b0, r_env} + ATK_EXT;

    always_comb begin
        w_env_next = r_env;
        if (i_gate) begin
            w_env_next = (w_up > ENV_MAX_EXT) ? ENV_FULL : w_up[ENV_W-1:0];
        end else if (r_env < REL_STEP) begin
            w_env_next = '0;
        end else begin
            w_env_next = r_env - REL_STEP;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_env <= '0;
        end else if (i_tick) begin
            r_env <= w_env_next;
        end
    end

    assign o_env       = r_env;
    assign o_is_silent = (r_env == '0);

endmodule

// File: rtl/poly_wavetable_synth.sv
// rtl/poly_wavetable_synth.sv - polyphonic wavetable voice mixer sharing one table BRAM across voices
// Optional 2x gain with saturation when POLY_SYNTH_SOFT_CLIP_EN is defined.
module poly_wavetable_synth
    import synth_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int SAMPLE_DIV   = 2500,
    parameter int PHASE_W      = 32,
    parameter int TABLE_AW     = DEF_TABLE_AW,
    parameter int SAMPLE_W     = DEF_SAMPLE_W,
    parameter int ENV_W        = DEF_ENV_W,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [NUM_VOICES-1:0]               voice_gate_in,
    input  logic [NUM_VOICES-1:0][PHASE_W-1:0]  voice_tuning_in,
    output logic [TABLE_AW-1:0]                 table_addr_out,
    input  logic [SAMPLE_W-1:0]                 table_data_in,
    output logic [SAMPLE_W-1:0]                 sample_out,
    output logic                                sample_valid_out,
    output logic                                busy_out
);

    localparam int LOG2_N  = $clog2(NUM_VOICES);
    localparam int ACC_W   = SAMPLE_W + LOG2_N;
    localparam int PROD_W  = SAMPLE_W + ENV_W + 1;
    localparam int CNT_W   = $clog2(SAMPLE_DIV);
    localparam int DRAIN_W = (TABLE_LAT > 1) ? $clog2(TABLE_LAT) : 1;

    localparam logic [LOG2_N-1:0]  LAST_VOICE = LOG2_N'(NUM_VOICES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(TABLE_LAT - 1);
    localparam logic [SAMPLE_W-1:0] SILENCE   = {1'b1, {(SAMPLE_W-1){1'b0}}};

    if (SAMPLE_DIV < NUM_VOICES + 4) begin : g_bad_div
        $error("SAMPLE_DIV must be at least NUM_VOICES+4");
    end
    if (NUM_VOICES < 2 || NUM_VOICES > 16 || (NUM_VOICES & (NUM_VOICES - 1)) != 0) begin : g_bad_voices
        $error("NUM_VOICES must be a power of two in 2..16");
    end

    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;

    assign w_tick = (r_tick_cnt == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    logic [ENV_W-1:0]      w_env        [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_silent;
    logic [PHASE_W-1:0]    r_phase      [NUM_VOICES];
    logic [PHASE_W-1:0]    w_phase_next [NUM_VOICES];

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_envelope #(
            .ENV_W        (ENV_W),
            .ATTACK_STEP  (ATTACK_STEP),
            .RELEASE_STEP (RELEASE_STEP)
        ) u_env (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .i_tick      (w_tick),
            .i_gate      (voice_gate_in[v]),
            .o_env       (w_env[v]),
            .o_is_silent (w_silent[v])
        );

        // A released, fully decayed voice parks at phase 0 so a retrigger starts cleanly.
        assign w_phase_next[v] = (!voice_gate_in[v] && w_silent[v]) ? '0
                               : r_phase[v] + voice_tuning_in[v];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int v = 0; v < NUM_VOICES; v++) r_phase[v] <= '0;
        end else if (w_tick) begin
            for (int v = 0; v < NUM_VOICES; v++) r_phase[v] <= w_phase_next[v];
        end
    end

    synth_state_t       r_state;
    synth_state_t       w_state_next;
    logic [LOG2_N-1:0]  r_voice_idx;
    logic [LOG2_N-1:0]  w_idx_inc;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [TABLE_AW-1:0] r_table_addr;

    assign w_idx_inc = r_voice_idx + LOG2_N'(1);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_tick) w_state_next = ISSUE;
            ISSUE:   if (r_voice_idx == LAST_VOICE) w_state_next = DRAIN;
            DRAIN:   if (r_drain_cnt == DRAIN_LAST) w_state_next = OUTPUT;
            OUTPUT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Voice 0's address comes straight from the phase being committed at the tick.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_table_addr <= '0;
            r_voice_idx  <= '0;
            r_drain_cnt  <= '0;
        end else begin
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;
            if (w_tick) begin
                r_table_addr <= w_phase_next[0][PHASE_W-1 -: TABLE_AW];
                r_voice_idx  <= '0;
            end else if (r_state == ISSUE) begin
                r_voice_idx <= w_idx_inc;
                if (r_voice_idx != LAST_VOICE) begin
                    r_table_addr <= r_phase[w_idx_inc][PHASE_W-1 -: TABLE_AW];
                end
            end
        end
    end

    logic [TABLE_LAT-1:0] r_rd_vld;
    logic [LOG2_N-1:0]    r_rd_idx [TABLE_LAT];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rd_vld <= '0;
            for (int i = 0; i < TABLE_LAT; i++) r_rd_idx[i] <= '0;
        end else begin
            r_rd_vld    <= {r_rd_vld[TABLE_LAT-2:0], r_state == ISSUE};
            r_rd_idx[0] <= r_voice_idx;
            for (int i = 1; i < TABLE_LAT; i++) r_rd_idx[i] <= r_rd_idx[i-1];
        end
    end

    logic                       w_rd_vld;
    logic [LOG2_N-1:0]          w_rd_idx;
    logic                       w_rd_last;
    logic signed [SAMPLE_W-1:0] w_s;
    logic signed [PROD_W-1:0]   w_s_ext;
    logic [PROD_W-1:0]          w_env_ext;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [SAMPLE_W-1:0] w_p;
    logic signed [ACC_W-1:0]    w_p_ext;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [SAMPLE_W-1:0] w_mix;

    assign w_rd_vld   = r_rd_vld[TABLE_LAT-1];
    assign w_rd_idx   = r_rd_idx[TABLE_LAT-1];
    assign w_rd_last  = w_rd_vld && (w_rd_idx == LAST_VOICE);
    assign w_s        = offset_to_signed(table_data_in);
    assign w_s_ext    = PROD_W'(w_s);
    assign w_env_ext  = PROD_W'(w_env[w_rd_idx]);
    assign w_prod     = w_s_ext * $signed(w_env_ext);
    assign w_p        = SAMPLE_W'(w_prod >>> ENV_W);
    assign w_p_ext    = ACC_W'(w_p);
    assign w_acc_next = r_acc + w_p_ext;

`ifdef POLY_SYNTH_SOFT_CLIP_EN
    localparam logic signed [ACC_W-1:0] MIX_MAX = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIX_MIN = ACC_W'(-(2 ** (SAMPLE_W - 1)));

    logic signed [ACC_W-1:0] w_gain;

    assign w_gain = w_acc_next >>> (LOG2_N - 1);

    always_comb begin
        w_mix = SAMPLE_W'(w_gain);
        if (w_gain > MIX_MAX) begin
            w_mix = SAMPLE_W'(MIX_MAX);
        end else if (w_gain < MIX_MIN) begin
            w_mix = SAMPLE_W'(MIX_MIN);
        end
    end
`else
    assign w_mix = SAMPLE_W'(w_acc_next >>> LOG2_N);
`endif

    logic [SAMPLE_W-1:0] r_sample;
    logic                r_valid;

    // The last voice's product is folded in combinationally so valid lands N+3 cycles after the tick.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_acc    <= '0;
            r_sample <= SILENCE;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_rd_last;
            if (w_tick) begin
                r_acc <= '0;
            end else if (w_rd_vld) begin
                r_acc <= w_acc_next;
            end
            if (w_rd_last) begin
                r_sample <= signed_to_offset(w_mix);
            end
        end
    end

    assign table_addr_out   = r_table_addr;
    assign sample_out       = r_sample;
    assign sample_valid_out = r_valid;
    assign busy_out         = (r_state == ISSUE) || (r_state == DRAIN);

endmodule
